calc_engine: RTL and testbench

CALC_ENGINE -- requirements
Module: calc_engine

---
 rtl/calc_engine.sv | 170 +++++++++++++++++
 tb/tb_calc_engine.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_engine.sv
// Accumulator calculator driven by a synchronised pushbutton strobe.
// Optional shift-add multiplier enabled by defining CALC_ENGINE_MUL_EN.
module calc_engine #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] NumIn,
   input  logic [2:0]       OpIn,
   input  logic             Enter,
   output logic [WIDTH-1:0] NumOut,
   output logic             Carry,
   output logic             Zero,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_OR   = 3'b010,
      OP_EQ   = 3'b011,
      OP_AND  = 3'b100,
      OP_XOR  = 3'b101,
      OP_MUL  = 3'b110,
      OP_LOAD = 3'b111
   } opcode_t;

`ifdef CALC_ENGINE_MUL_EN
   typedef enum logic {IDLE, MUL} state_t;
   localparam int CW = $clog2(WIDTH);
`else
   typedef enum logic {IDLE} state_t;
`endif

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, hist_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             accept;
   logic [WIDTH:0]   addSum;
   opcode_t          op;

`ifdef CALC_ENGINE_MUL_EN
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] mulStep;

   assign mulStep = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

   assign accept = sync2_q & ~hist_q;
   assign addSum = {1'b0, acc_q} + {1'b0, NumIn};
   assign op     = opcode_t'(OpIn);

   // Synchroniser and history reset high so a button held through reset is not an edge.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         hist_q   <= 1'b1;
         state_q  <= IDLE;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef CALC_ENGINE_MUL_EN
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         count_q  <= '0;
`endif
      end else begin
         sync1_q  <= Enter;
         sync2_q  <= sync1_q;
         hist_q   <= sync2_q;
         state_q  <= state_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef CALC_ENGINE_MUL_EN
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef CALC_ENGINE_MUL_EN
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      count_d  = count_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               done_d  = 1'b1;
               carry_d = 1'b0;
               case (op)
                  OP_ADD: begin
                     acc_d   = addSum[WIDTH-1:0];
                     carry_d = addSum[WIDTH];
                  end
                  OP_SUB: begin
                     acc_d   = acc_q - NumIn;
                     carry_d = (NumIn > acc_q);
                  end
                  OP_OR:   acc_d = acc_q | NumIn;
                  OP_EQ:   acc_d = WIDTH'(acc_q == NumIn);
                  OP_AND:  acc_d = acc_q & NumIn;
                  OP_XOR:  acc_d = acc_q ^ NumIn;
                  OP_MUL: begin
`ifdef CALC_ENGINE_MUL_EN
                     done_d   = 1'b0;
                     carry_d  = carry_q;
                     mcand_d  = {{WIDTH{1'b0}}, acc_q};
                     mplier_d = NumIn;
                     prod_d   = '0;
                     count_d  = '0;
                     busy_d   = 1'b1;
                     state_d  = MUL;
`else
                     carry_d  = carry_q;
`endif
                  end
                  OP_LOAD: acc_d = NumIn;
                  default: acc_d = acc_q;
               endcase
            end
         end
`ifdef CALC_ENGINE_MUL_EN
         // One partial product per cycle; the last step writes straight into acc.
         MUL: begin
            prod_d   = mulStep;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
            if (count_q == CW'(WIDTH - 1)) begin
               acc_d   = mulStep[WIDTH-1:0];
               carry_d = |mulStep[2*WIDTH-1:WIDTH];
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign NumOut = acc_q;
   assign Carry  = carry_q;
   assign Zero   = (acc_q == '0);
   assign Busy   = busy_q;
   assign Done   = done_q;

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine with a behavioural accumulator model.
// Covers CALC_ENGINE_MUL_EN builds and default builds.
module tb_calc_engine;

   localparam int W = 8;
   localparam int WINDOW = W + 8;
`ifdef CALC_ENGINE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clock;
   logic         Reset;
   logic [W-1:0] NumIn;
   logic [2:0]   OpIn;
   logic         Enter;
   logic [W-1:0] NumOut;
   logic         Carry;
   logic         Zero;
   logic         Busy;
   logic         Done;

   int errors = 0;
   int checks = 0;

   int unsigned modelAcc;
   bit          modelCarry;

   calc_engine #(.WIDTH(W)) dut (
      .clock  (clock),
      .Reset  (Reset),
      .NumIn  (NumIn),
      .OpIn   (OpIn),
      .Enter  (Enter),
      .NumOut (NumOut),
      .Carry  (Carry),
      .Zero   (Zero),
      .Busy   (Busy),
      .Done   (Done)
   );

   // Free-running 10-unit clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model: plain arithmetic on a WIDTH-bit accumulator
   function automatic void applyModel(input logic [2:0] op, input logic [W-1:0] num);
      longint unsigned a, n, r;
      a = longint'(modelAcc);
      n = longint'(num);
      case (op)
         3'd0: begin r = a + n; modelCarry = (r >= (64'd1 << W)); end
         3'd1: begin r = (a + (64'd1 << W) - n); modelCarry = (n > a); end
         3'd2: begin r = a | n; modelCarry = 1'b0; end
         3'd3: begin r = (a == n) ? 64'd1 : 64'd0; modelCarry = 1'b0; end
         3'd4: begin r = a & n; modelCarry = 1'b0; end
         3'd5: begin r = a ^ n; modelCarry = 1'b0; end
         3'd6: begin
            if (MUL_EN) begin
               r = a * n;
               modelCarry = ((r >> W) != 0);
            end else begin
               r = a;
            end
         end
         default: begin r = n; modelCarry = 1'b0; end
      endcase
      modelAcc = int'(r % (64'd1 << W));
   endfunction

   function automatic int expDoneIdx(input logic [2:0] op);
      return (op == 3'd6 && MUL_EN) ? 3 + W : 3;
   endfunction

   function automatic int expBusy(input logic [2:0] op);
      return (op == 3'd6 && MUL_EN) ? W : 0;
   endfunction

   // Issue one command and observe Done/Busy over a bounded window
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] num, input bit toggle,
                                output int doneCnt, output int doneIdx, output int busyCnt,
                                output bit oldHeld);
      doneCnt = 0;
      doneIdx = -1;
      busyCnt = 0;
      oldHeld = 1'b1;
      @(negedge clock);
      NumIn = num;
      OpIn  = op;
      Enter = 1'b1;
      for (int k = 1; k <= WINDOW; k++) begin
         @(negedge clock);
         if (!Done && doneCnt == 0 && NumOut !== W'(modelAcc)) oldHeld = 1'b0;
         if (Done) begin
            doneCnt++;
            if (doneIdx < 0) doneIdx = k;
         end
         if (Busy) busyCnt++;
         if (toggle && k == 5) Enter = 1'b0;
         if (toggle && k == 8) Enter = 1'b1;
      end
      Enter = 1'b0;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_reset;
      Enter = 1'b1;
      NumIn = '0;
      OpIn  = 3'd7;
      Reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (NumOut !== 8'h00 || Carry !== 1'b0 || Zero !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: got NumOut=%h Carry=%b Zero=%b Busy=%b Done=%b required 00 0 1 0 0",
                  NumOut, Carry, Zero, Busy, Done);
      end
      Reset = 1'b1;
      begin
         int doneSeen;
         doneSeen = 0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (Done) doneSeen++;
         end
         checks++;
         if (doneSeen != 0 || NumOut !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_enter_held: got done=%0d NumOut=%h required done=0 NumOut=00",
                     doneSeen, NumOut);
         end
      end
      Enter = 1'b0;
      repeat (4) @(negedge clock);
      modelAcc   = 0;
      modelCarry = 1'b0;
   endtask

   task automatic test_add_wrap;
      int dc, di, bc;
      bit oh;
      applyStimulus(3'd7, 8'hFF, 1'b0, dc, di, bc, oh);
      applyModel(3'd7, 8'hFF);
      checks++;
      if (NumOut !== 8'hFF || Carry !== 1'b0 || dc != 1 || di != 3 || !oh) begin
         errors++;
         $display("[TB] FAIL load_ff: got NumOut=%h Carry=%b done=%0d at=%0d held=%b required FF 0 1 3 1",
                  NumOut, Carry, dc, di, oh);
      end
      applyStimulus(3'd0, 8'h01, 1'b0, dc, di, bc, oh);
      applyModel(3'd0, 8'h01);
      checks++;
      if (NumOut !== 8'h00 || Carry !== 1'b1 || Zero !== 1'b1 || dc != 1 || di != 3) begin
         errors++;
         $display("[TB] FAIL add_wrap: got NumOut=%h Carry=%b Zero=%b done=%0d at=%0d required 00 1 1 1 3",
                  NumOut, Carry, Zero, dc, di);
      end
   endtask

   task automatic test_sub_eq;
      int dc, di, bc;
      bit oh;
      applyStimulus(3'd1, 8'h01, 1'b0, dc, di, bc, oh);
      applyModel(3'd1, 8'h01);
      checks++;
      if (NumOut !== 8'hFF || Carry !== 1'b1 || Zero !== 1'b0 || dc != 1) begin
         errors++;
         $display("[TB] FAIL sub_borrow: got NumOut=%h Carry=%b Zero=%b done=%0d required FF 1 0 1",
                  NumOut, Carry, Zero, dc);
      end
      applyStimulus(3'd3, 8'hFF, 1'b0, dc, di, bc, oh);
      applyModel(3'd3, 8'hFF);
      checks++;
      if (NumOut !== 8'h01 || Carry !== 1'b0 || dc != 1) begin
         errors++;
         $display("[TB] FAIL eq_true: got NumOut=%h Carry=%b done=%0d required 01 0 1", NumOut, Carry, dc);
      end
   endtask

`ifdef CALC_ENGINE_MUL_EN
   task automatic test_mul;
      int dc, di, bc;
      bit oh;
      applyStimulus(3'd7, 8'h12, 1'b0, dc, di, bc, oh);
      applyModel(3'd7, 8'h12);
      applyStimulus(3'd6, 8'h10, 1'b0, dc, di, bc, oh);
      applyModel(3'd6, 8'h10);
      checks++;
      if (NumOut !== 8'h20 || Carry !== 1'b1 || bc != W || dc != 1 || di != 3 + W || !oh) begin
         errors++;
         $display("[TB] FAIL mul_overflow: got NumOut=%h Carry=%b busy=%0d done=%0d at=%0d held=%b required 20 1 %0d 1 %0d 1",
                  NumOut, Carry, bc, dc, di, oh, W, 3 + W);
      end
      applyStimulus(3'd7, 8'h03, 1'b0, dc, di, bc, oh);
      applyModel(3'd7, 8'h03);
      applyStimulus(3'd6, 8'h05, 1'b0, dc, di, bc, oh);
      applyModel(3'd6, 8'h05);
      checks++;
      if (NumOut !== 8'h0F || Carry !== 1'b0 || bc != W || dc != 1) begin
         errors++;
         $display("[TB] FAIL mul_small: got NumOut=%h Carry=%b busy=%0d done=%0d required 0F 0 %0d 1",
                  NumOut, Carry, bc, dc, W);
      end
   endtask

   task automatic test_busy_ignore;
      int dc, di, bc;
      bit oh;
      applyStimulus(3'd7, 8'h07, 1'b0, dc, di, bc, oh);
      applyModel(3'd7, 8'h07);
      applyStimulus(3'd6, 8'h03, 1'b1, dc, di, bc, oh);
      applyModel(3'd6, 8'h03);
      checks++;
      if (NumOut !== 8'h15 || dc != 1 || bc != W) begin
         errors++;
         $display("[TB] FAIL busy_ignore: got NumOut=%h done=%0d busy=%0d required 15 1 %0d",
                  NumOut, dc, bc, W);
      end
   endtask

   task automatic test_reset_mid_mul;
      int dc, di, bc, doneSeen;
      bit oh;
      applyStimulus(3'd7, 8'h09, 1'b0, dc, di, bc, oh);
      applyModel(3'd7, 8'h09);
      @(negedge clock);
      NumIn = 8'h04;
      OpIn  = 3'd6;
      Enter = 1'b1;
      repeat (6) @(negedge clock);
      checks++;
      if (Busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_mul_busy: got Busy=%b required 1", Busy);
      end
      Reset = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         if (Done) doneSeen++;
      end
      Reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (Done) doneSeen++;
      end
      checks++;
      if (NumOut !== 8'h00 || Busy !== 1'b0 || doneSeen != 0) begin
         errors++;
         $display("[TB] FAIL reset_mid_mul: got NumOut=%h Busy=%b done=%0d required 00 0 0",
                  NumOut, Busy, doneSeen);
      end
      Enter = 1'b0;
      repeat (4) @(negedge clock);
      modelAcc   = 0;
      modelCarry = 1'b0;
      applyStimulus(3'd0, 8'h05, 1'b0, dc, di, bc, oh);
      applyModel(3'd0, 8'h05);
      checks++;
      if (NumOut !== 8'h05 || dc != 1) begin
         errors++;
         $display("[TB] FAIL after_reset_cmd: got NumOut=%h done=%0d required 05 1", NumOut, dc);
      end
   endtask
`else
   task automatic test_mul_noop;
      int dc, di, bc;
      bit oh;
      applyStimulus(3'd7, 8'h07, 1'b0, dc, di, bc, oh);
      applyModel(3'd7, 8'h07);
      applyStimulus(3'd6, 8'h02, 1'b0, dc, di, bc, oh);
      applyModel(3'd6, 8'h02);
      checks++;
      if (NumOut !== 8'h07 || Carry !== 1'b0 || dc != 1 || di != 3 || bc != 0) begin
         errors++;
         $display("[TB] FAIL mul_noop: got NumOut=%h Carry=%b done=%0d at=%0d busy=%0d required 07 0 1 3 0",
                  NumOut, Carry, dc, di, bc);
      end
      applyStimulus(3'd0, 8'hFA, 1'b0, dc, di, bc, oh);
      applyModel(3'd0, 8'hFA);
      applyStimulus(3'd6, 8'h33, 1'b0, dc, di, bc, oh);
      applyModel(3'd6, 8'h33);
      checks++;
      if (NumOut !== 8'h01 || Carry !== 1'b1 || dc != 1 || bc != 0) begin
         errors++;
         $display("[TB] FAIL mul_noop_carry: got NumOut=%h Carry=%b done=%0d busy=%0d required 01 1 1 0",
                  NumOut, Carry, dc, bc);
      end
   endtask
`endif

   task automatic test_random;
      int dc, di, bc;
      bit oh;
      logic [2:0]   op;
      logic [W-1:0] num;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       num = '0;
            1:       num = '1;
            2:       num = W'(modelAcc);
            default: num = W'($urandom);
         endcase
         applyStimulus(op, num, 1'b0, dc, di, bc, oh);
         applyModel(op, num);
         checks++;
         if (NumOut !== W'(modelAcc) || Carry !== modelCarry || Zero !== (modelAcc == 0)) begin
            errors++;
            $display("[TB] FAIL random_result[%0d] op=%0d num=%h: got NumOut=%h Carry=%b Zero=%b required %h %b %b",
                     i, op, num, NumOut, Carry, Zero, W'(modelAcc), modelCarry, (modelAcc == 0));
         end
         checks++;
         if (dc != 1 || di != expDoneIdx(op) || bc != expBusy(op) || !oh) begin
            errors++;
            $display("[TB] FAIL random_timing[%0d] op=%0d: got done=%0d at=%0d busy=%0d held=%b required 1 %0d %0d 1",
                     i, op, dc, di, bc, oh, expDoneIdx(op), expBusy(op));
         end
      end
   endtask

   initial begin
      Reset = 1'b1;
      Enter = 1'b0;
      NumIn = '0;
      OpIn  = '0;
      modelAcc   = 0;
      modelCarry = 1'b0;
      #2;
      test_reset();
      test_add_wrap();
      test_sub_eq();
`ifdef CALC_ENGINE_MUL_EN
      test_mul();
      test_busy_ignore();
      test_reset_mid_mul();
`else
      test_mul_noop();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
